// File: rtl/dds_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// dds_sweep_ctrl
// Frequency-sweep scheduler for one DDS channel. A sweep steps the channel
// frequency word from a start value to a stop value in fixed increments and
// holds each point for a programmable number of clocks. In sawtooth mode each
// lap runs upward only. In triangle mode each lap runs up and then back down.
// A sweep runs for a programmable number of laps, or until abort.
//
// Ports
//   clk, rst      system clock; synchronous active-high reset
//   start         1-cycle sweep request, honoured only while idle
//   abort         stop the running sweep at once (wins over a step)
//   cfg_*         sweep configuration, captured on an accepted start
//   f_word_out    current frequency word for the channel
//   f_word_vld    pulse on the first cycle of every loaded point
//   phase_sync    pulse when a lap (re)loads the start word
//   sweep_busy    high while a sweep runs
//   sweep_done    pulse when the final lap completes
//   cfg_err       pulse when a start is rejected (step==0 or start>stop)
//   state_dbg     current FSM state (IDLE=0, UP=1, DOWN=2)
//
// Handshake: start and abort are single-cycle level-sampled requests. There
// is no back-pressure. Outputs are registered, and each pulse output is high
// for exactly one clock.
// ---------------------------------------------------------------------------
module dds_sweep_ctrl #(
    parameter int FW_W  = 32,
    parameter int CNT_W = 32,
    parameter int REP_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [FW_W-1:0]  cfg_f_start,
    input  logic [FW_W-1:0]  cfg_f_stop,
    input  logic [FW_W-1:0]  cfg_f_step,
    input  logic [CNT_W-1:0] cfg_dwell,
    input  logic             cfg_mode,
    input  logic [REP_W-1:0] cfg_repeat,
    output logic [FW_W-1:0]  f_word_out,
    output logic             f_word_vld,
    output logic             phase_sync,
    output logic             sweep_busy,
    output logic             sweep_done,
    output logic             cfg_err,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [FW_W-1:0]  f_q, f_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [REP_W-1:0] laps_q, laps_d;
    logic [FW_W-1:0]  start_q, start_d;
    logic [FW_W-1:0]  stop_q, stop_d;
    logic [FW_W-1:0]  step_q, step_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic             mode_q, mode_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic             vld_q, vld_d;
    logic             sync_q, sync_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    // Next-point candidates, computed one bit wider so that a step past the
    // top of the word range clips to stop instead of wrapping to zero.
    logic [FW_W:0]    up_sum, dn_diff, rs_sum;
    logic [FW_W-1:0]  up_next, dn_next, rs_next;
    logic [REP_W:0]   laps_inc;
    logic             more_laps;
    logic [CNT_W-1:0] dwell_eff_in;

    always_comb begin
        up_sum  = {1'b0, f_q} + {1'b0, step_q};
        up_next = (up_sum > {1'b0, stop_q}) ? stop_q : up_sum[FW_W-1:0];

        dn_diff = {1'b0, f_q} - {1'b0, step_q};
        dn_next = (dn_diff[FW_W] || (dn_diff[FW_W-1:0] < start_q)) ? start_q : dn_diff[FW_W-1:0];

        // First point of a later triangle lap: one step above start.
        rs_sum  = {1'b0, start_q} + {1'b0, step_q};
        rs_next = (rs_sum > {1'b0, stop_q}) ? stop_q : rs_sum[FW_W-1:0];

        laps_inc  = {1'b0, laps_q} + (REP_W+1)'(1);
        more_laps = (rep_q == '0) || (laps_inc < {1'b0, rep_q});

        dwell_eff_in = (cfg_dwell == '0) ? CNT_W'(1) : cfg_dwell;
    end

    always_comb begin
        state_d = state_q;
        f_d     = f_q;
        cnt_d   = cnt_q;
        laps_d  = laps_q;
        start_d = start_q;
        stop_d  = stop_q;
        step_d  = step_q;
        dwell_d = dwell_q;
        mode_d  = mode_q;
        rep_d   = rep_q;
        vld_d   = 1'b0;
        sync_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    if ((cfg_f_step == '0) || (cfg_f_start > cfg_f_stop)) begin
                        err_d = 1'b1;
                    end else begin
                        start_d = cfg_f_start;
                        stop_d  = cfg_f_stop;
                        step_d  = cfg_f_step;
                        dwell_d = dwell_eff_in;
                        mode_d  = cfg_mode;
                        rep_d   = cfg_repeat;
                        f_d     = cfg_f_start;
                        cnt_d   = dwell_eff_in - CNT_W'(1);
                        laps_d  = '0;
                        vld_d   = 1'b1;
                        sync_d  = 1'b1;
                        state_d = S_UP;
                    end
                end
            end

            S_UP, S_DOWN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // Last cycle of the current point: decide what comes next.
                    cnt_d = dwell_q - CNT_W'(1);
                    if (state_q == S_UP && f_q < stop_q) begin
                        f_d   = up_next;
                        vld_d = 1'b1;
                    end else if (state_q == S_UP && mode_q && start_q != stop_q) begin
                        f_d     = dn_next;
                        vld_d   = 1'b1;
                        state_d = S_DOWN;
                    end else if (state_q == S_DOWN && f_q > start_q) begin
                        f_d   = dn_next;
                        vld_d = 1'b1;
                    end else if (more_laps) begin
                        // Lap end with laps remaining. The lap counter saturates,
                        // which only matters for the endless (repeat==0) case.
                        laps_d  = laps_inc[REP_W] ? laps_q : laps_inc[REP_W-1:0];
                        vld_d   = 1'b1;
                        state_d = S_UP;
                        if (!mode_q || start_q == stop_q) begin
                            f_d    = start_q;
                            sync_d = 1'b1;
                        end else begin
                            f_d = rs_next;
                        end
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            f_q     <= '0;
            cnt_q   <= '0;
            laps_q  <= '0;
            start_q <= '0;
            stop_q  <= '0;
            step_q  <= '0;
            dwell_q <= '0;
            mode_q  <= 1'b0;
            rep_q   <= '0;
            vld_q   <= 1'b0;
            sync_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            f_q     <= f_d;
            cnt_q   <= cnt_d;
            laps_q  <= laps_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            step_q  <= step_d;
            dwell_q <= dwell_d;
            mode_q  <= mode_d;
            rep_q   <= rep_d;
            vld_q   <= vld_d;
            sync_q  <= sync_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign f_word_out = f_q;
    assign f_word_vld = vld_q;
    assign phase_sync = sync_q;
    assign sweep_busy = (state_q != S_IDLE);
    assign sweep_done = done_q;
    assign cfg_err    = err_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dds_sweep_ctrl
// Directed and randomized sweeps. The expected point list of a sweep is built
// from the sweep rules with plain integer arithmetic: sawtooth laps climb from
// start to stop, and triangle laps climb and then descend. It is then expanded
// cycle by cycle using the dwell time. Inputs change on the falling edge, and
// outputs are checked on the falling edge.
// ---------------------------------------------------------------------------
module tb_dds_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] cfg_f_start;
    logic [31:0] cfg_f_stop;
    logic [31:0] cfg_f_step;
    logic [31:0] cfg_dwell;
    logic        cfg_mode;
    logic [7:0]  cfg_repeat;
    logic [31:0] f_word_out;
    logic        f_word_vld;
    logic        phase_sync;
    logic        sweep_busy;
    logic        sweep_done;
    logic        cfg_err;
    logic [1:0]  state_dbg;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] exp_q[$];
    bit          sync_q[$];

    dds_sweep_ctrl #(.FW_W(32), .CNT_W(32), .REP_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .cfg_f_start (cfg_f_start),
        .cfg_f_stop  (cfg_f_stop),
        .cfg_f_step  (cfg_f_step),
        .cfg_dwell   (cfg_dwell),
        .cfg_mode    (cfg_mode),
        .cfg_repeat  (cfg_repeat),
        .f_word_out  (f_word_out),
        .f_word_vld  (f_word_vld),
        .phase_sync  (phase_sync),
        .sweep_busy  (sweep_busy),
        .sweep_done  (sweep_done),
        .cfg_err     (cfg_err),
        .state_dbg   (state_dbg)
    );

    // clock / reset
    always #4 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cycle(input string tag, input logic [31:0] f, input logic vld,
                             input logic sync, input logic busy, input logic done);
        chk({tag, ".f"},    64'(f_word_out), 64'(f));
        chk({tag, ".vld"},  64'(f_word_vld), 64'(vld));
        chk({tag, ".sync"}, 64'(phase_sync), 64'(sync));
        chk({tag, ".busy"}, 64'(sweep_busy), 64'(busy));
        chk({tag, ".done"}, 64'(sweep_done), 64'(done));
    endtask

    // Reference: list of points of the whole sweep, with phase-sync flags.
    function automatic void build(input longint s, input longint e, input longint st,
                                  input bit md, input int laps);
        longint v;
        exp_q.delete();
        sync_q.delete();
        for (int lap = 0; lap < laps; lap++) begin
            v = s;
            if (!md || s == e) begin
                exp_q.push_back(v[31:0]);
                sync_q.push_back(1'b1);
                while (v < e) begin
                    v = (v + st > e) ? e : v + st;
                    exp_q.push_back(v[31:0]);
                    sync_q.push_back(1'b0);
                end
            end else begin
                if (lap == 0) begin
                    exp_q.push_back(v[31:0]);
                    sync_q.push_back(1'b1);
                end
                while (v < e) begin
                    v = (v + st > e) ? e : v + st;
                    exp_q.push_back(v[31:0]);
                    sync_q.push_back(1'b0);
                end
                while (v > s) begin
                    v = (v - st < s) ? s : v - st;
                    exp_q.push_back(v[31:0]);
                    sync_q.push_back(1'b0);
                end
            end
        end
    endfunction

    // driver: one whole sweep, checked every cycle
    task automatic run_sweep(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                             input logic [31:0] dw, input logic md, input logic [7:0] rep,
                             input int abort_at, input bit noise);
        int d, total, laps, ab, i;
        d    = (dw == 0) ? 1 : int'(dw);
        laps = (rep == 0) ? 3 : int'(rep);
        build(longint'(s), longint'(e), longint'(st), md, laps);
        total = exp_q.size() * d;
        ab = abort_at;
        if (rep == 0 && ab < 0) ab = total - 1;
        if (ab >= total) ab = total - 1;

        @(negedge clk);
        cfg_f_start = s; cfg_f_stop = e; cfg_f_step = st;
        cfg_dwell = dw; cfg_mode = md; cfg_repeat = rep;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < total; t++) begin
            i = t / d;
            chk_cycle("point", exp_q[i], (t % d) == 0, ((t % d) == 0) && sync_q[i], 1'b1, 1'b0);
            if (t == ab) begin
                start = 1'b0;
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                chk_cycle("abort", exp_q[i], 1'b0, 1'b0, 1'b0, 1'b0);
                chk("abort.state", 64'(state_dbg), 64'd0);
                @(negedge clk);
                chk_cycle("abort_after", exp_q[i], 1'b0, 1'b0, 1'b0, 1'b0);
                return;
            end
            if (noise && t < total - 1) begin
                cfg_f_start = $urandom;
                cfg_f_stop  = $urandom;
                cfg_f_step  = $urandom_range(0, 3);
                cfg_dwell   = $urandom_range(0, 5);
                cfg_mode    = 1'($urandom_range(0, 1));
                cfg_repeat  = 8'($urandom_range(0, 4));
                start       = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk_cycle("done", exp_q[exp_q.size()-1], 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk_cycle("idle", exp_q[exp_q.size()-1], 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic try_start(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                             input logic ab, input logic exp_err);
        @(negedge clk);
        cfg_f_start = s; cfg_f_stop = e; cfg_f_step = st;
        cfg_dwell = 32'd2; cfg_mode = 1'b0; cfg_repeat = 8'd1;
        start = 1'b1;
        abort = ab;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("err.pulse", 64'(cfg_err), 64'(exp_err));
        chk("err.busy",  64'(sweep_busy), 64'd0);
        chk("err.vld",   64'(f_word_vld), 64'd0);
        @(negedge clk);
        chk("err.clear", 64'(cfg_err), 64'd0);
        chk("err.busy2", 64'(sweep_busy), 64'd0);
    endtask

    initial begin
        int rs, rst_step, re, rdw, rab;
        logic rmd;
        logic [7:0] rrep;

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_f_start = '0; cfg_f_stop = '0; cfg_f_step = '0;
        cfg_dwell = '0; cfg_mode = 1'b0; cfg_repeat = '0;
        @(negedge clk);
        @(negedge clk);
        chk_cycle("reset", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.err", 64'(cfg_err), 64'd0);
        chk("reset.state", 64'(state_dbg), 64'd0);
        rst = 1'b0;

        // directed sweeps
        run_sweep(32'd100, 32'd130, 32'd10, 32'd4, 1'b0, 8'd1, -1, 1'b0);
        run_sweep(32'd0, 32'd25, 32'd10, 32'd1, 1'b0, 8'd2, -1, 1'b0);
        run_sweep(32'd0, 32'd20, 32'd10, 32'd2, 1'b1, 8'd2, -1, 1'b0);
        run_sweep(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h10, 32'd1, 1'b0, 8'd1, -1, 1'b0);
        run_sweep(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h70, 32'd1, 1'b1, 8'd2, -1, 1'b0);
        run_sweep(32'd100, 32'd130, 32'd10, 32'd4, 1'b0, 8'd1, 8, 1'b1);
        run_sweep(32'd100, 32'd130, 32'd10, 32'd1, 1'b1, 8'd1, 2, 1'b1);
        run_sweep(32'd50, 32'd50, 32'd3, 32'd2, 1'b1, 8'd3, -1, 1'b0);
        run_sweep(32'd5, 32'd35, 32'd7, 32'd0, 1'b1, 8'd0, -1, 1'b1);

        // rejected and suppressed starts
        try_start(32'd10, 32'd20, 32'd0, 1'b0, 1'b1);
        try_start(32'd30, 32'd20, 32'd5, 1'b0, 1'b1);
        try_start(32'd10, 32'd20, 32'd5, 1'b1, 1'b0);

        // reset in the middle of a sweep
        @(negedge clk);
        cfg_f_start = 32'd200; cfg_f_stop = 32'd400; cfg_f_step = 32'd20;
        cfg_dwell = 32'd3; cfg_mode = 1'b1; cfg_repeat = 8'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid.busy", 64'(sweep_busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_cycle("midreset", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("midreset.state", 64'(state_dbg), 64'd0);

        // randomized sweeps
        for (int n = 0; n < 20; n++) begin
            rs       = $urandom_range(0, 1000);
            rst_step = $urandom_range(1, 50);
            re       = rs + $urandom_range(0, 6 * rst_step);
            rdw      = $urandom_range(0, 3);
            rmd      = 1'($urandom_range(0, 1));
            rrep     = 8'($urandom_range(0, 3));
            rab      = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : -1;
            run_sweep(32'(rs), 32'(re), 32'(rst_step), 32'(rdw), rmd, rrep, rab, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
